seq_gen_tx: RTL and testbench
=============================

SEQ_GEN_TX -- requirements
Module: seq_gen_tx

Interface
REQ-001 Parameter: WIDTH, 16, maximum frame length in bits.
REQ-002 Parameter: DET_PAT, 4'b1011, 4-bit pattern counted on the emitted stream.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 data  input  WIDTH  frame bits; bit len-1 is sent first (MSB-first).
REQ-007 len  input  5  frame length in bits, 1..WIDTH.
REQ-008 reps  input  4  extra repetitions; total frames = reps+1.
REQ-009 abort  input  1  terminates the transmission in progress.
REQ-010 x  output  1  serial bit stream, the detector's input line.
REQ-011 valid  output  1  x carries a frame bit this cycle.
REQ-012 busy  output  1  transmission in progress (not IDLE).
REQ-013 done  output  1  one-cycle pulse when transmission completes or aborts.
REQ-014 pat_cnt  output  8  count of overlapping DET_PAT occurrences in emitted valid bits.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, PARITY (present only with the macro) and DONE.
REQ-016 In IDLE with start=1 and 1<=len<=WIDTH, the block SHALL capture data, len and reps, clear pat_cnt and the pattern history, and enter SHIFT.
REQ-017 start SHALL be ignored when len=0, when len>WIDTH, and in any state other than IDLE.
REQ-018 The first bit SHALL appear on x with valid=1 in the cycle after start is accepted, one bit per cycle, MSB-first.
REQ-019 After bit 0 of a frame, if frames remain, the next frame SHALL begin on the next cycle with no gap, reloading the captured data.
REQ-020 After the last bit of the last frame, the FSM SHALL enter DONE for exactly one cycle with done=1, valid=0 and x=0, then return to IDLE.
REQ-021 Outside SHIFT and PARITY, x and valid SHALL be 0.
REQ-022 busy SHALL be 1 in SHIFT, PARITY and DONE.
REQ-023 abort=1 in SHIFT or PARITY SHALL go to DONE on the next edge; the bit on that cycle SHALL still be emitted and counted.
REQ-024 abort SHALL be ignored in IDLE and DONE.
REQ-025 pat_cnt SHALL increment when the last four valid bits, oldest first, equal DET_PAT; matches overlap, and history spans frame boundaries.
REQ-026 pat_cnt SHALL saturate at 255.
REQ-027 pat_cnt SHALL hold its value after DONE until the next accepted start.
REQ-028 A match SHALL require four valid bits since the last accepted start.

Reset
REQ-029 With rst_n=0 at a rising edge, the block SHALL enter IDLE and set x=0, valid=0, busy=0, done=0, pat_cnt=0, and clear the history.
REQ-030 Reset SHALL take priority over start and abort, including in mid-transmission, where no done pulse SHALL be produced.

Configuration
REQ-031 Macro SEQ_GEN_TX_PARITY_EN defined: after bit 0 of each frame the FSM SHALL spend one PARITY cycle emitting the even-parity bit of the frame (XOR of the len bits), with valid=1, and that bit SHALL count toward pat_cnt.
REQ-032 Macro SEQ_GEN_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and frames SHALL be exactly len bits.

Verification
REQ-033 Single frame: len=4, data=4'b1011, reps=0 -> x=1,0,1,1 in cycles 1-4 with valid=1; done=1 in cycle 5; pat_cnt=1.
REQ-034 Overlap: len=7, data=7'b1011011, reps=0 -> x=1,0,1,1,0,1,1; pat_cnt=2.
REQ-035 Repeats: len=4, data=4'b1011, reps=2 -> 12 contiguous bits 101110111011; done in cycle 13; pat_cnt=3.
REQ-036 Abort and ignore: len=8, start, abort in cycle 3 -> 3 bits emitted, done in cycle 4; a start pulse in cycle 2 has no effect.
REQ-037 Reset mid-frame: rst_n=0 in cycle 2 of a transmission -> next cycle all outputs are 0 and the FSM is in IDLE; len=0 with start stays IDLE.
REQ-038 Parity (macro defined): len=4, data=4'b1011 -> x=1,0,1,1,1; done in cycle 6; pat_cnt=1.

Source files
------------

// File: rtl/seq_gen_tx.sv
// Serial frame transmitter (MSB-first, repeatable) with overlapping DET_PAT counter; SEQ_GEN_TX_PARITY_EN adds an even-parity bit per frame.
// Latency: first bit one cycle after an accepted start, then one bit per cycle; one-cycle done pulse after the last bit.
// Backpressure: none; start is taken only in IDLE, and abort ends the transmission after the current bit.
module seq_gen_tx #(
  parameter int         WIDTH   = 16,
  parameter logic [3:0] DET_PAT = 4'b1011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [4:0]       len,
  input  logic [3:0]       reps,
  input  logic             abort,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [7:0]       pat_cnt
);

  localparam int         IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] LEN_MAX = 6'(WIDTH);

`ifdef SEQ_GEN_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [IW-1:0]    idx_q, idx_d, last_q;
  logic [3:0]       reps_q, reps_d;
  logic             accept, load;
  logic [2:0]       hist_q;
  logic [1:0]       hcnt_q;
  logic             match;

`ifdef SEQ_GEN_TX_PARITY_EN
  logic             par_q, par_d;
  logic [WIDTH-1:0] len_mask;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      len_mask[i] = (i < int'(len));
    end
    par_d = ^(data & len_mask);
  end
`endif

  assign accept = start && (len != 5'd0) && ({1'b0, len} <= LEN_MAX);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

  always_comb begin
    x     = 1'b0;
    valid = 1'b0;
    case (state_q)
      SHIFT: begin
        x     = data_q[idx_q];
        valid = 1'b1;
      end
`ifdef SEQ_GEN_TX_PARITY_EN
      PARITY: begin
        x     = par_q;
        valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    reps_d  = reps_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = SHIFT;
          idx_d   = IW'(len - 5'd1);
          reps_d  = reps;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = DONE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end else begin
`ifdef SEQ_GEN_TX_PARITY_EN
          state_d = PARITY;
`else
          // Next frame starts back-to-back from the captured data.
          if (reps_q != 4'd0) begin
            reps_d = reps_q - 4'd1;
            idx_d  = last_q;
          end else begin
            state_d = DONE;
          end
`endif
        end
      end
`ifdef SEQ_GEN_TX_PARITY_EN
      PARITY: begin
        if (abort) begin
          state_d = DONE;
        end else if (reps_q != 4'd0) begin
          reps_d  = reps_q - 4'd1;
          idx_d   = last_q;
          state_d = SHIFT;
        end else begin
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Needs three earlier valid bits since the last start before a match can count.
  assign match = valid && (hcnt_q == 2'd3) && ({hist_q, x} == DET_PAT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      reps_q  <= '0;
      hist_q  <= '0;
      hcnt_q  <= '0;
      pat_cnt <= '0;
`ifdef SEQ_GEN_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      reps_q  <= reps_d;
      if (load) begin
        data_q  <= data;
        last_q  <= idx_d;
        hist_q  <= '0;
        hcnt_q  <= '0;
        pat_cnt <= '0;
`ifdef SEQ_GEN_TX_PARITY_EN
        par_q   <= par_d;
`endif
      end else if (valid) begin
        hist_q <= {hist_q[1:0], x};
        if (hcnt_q != 2'd3) hcnt_q <= hcnt_q + 2'd1;
        if (match && (pat_cnt != 8'hff)) pat_cnt <= pat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Scoreboard bench for seq_gen_tx: directed transmissions push expected bits/done events; a negedge monitor pops and compares.
module tb_seq_gen_tx;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data;
  logic [4:0]  len;
  logic [3:0]  reps;
  logic        abort;
  logic        x, valid, busy, done;
  logic [7:0]  pat_cnt;

  seq_gen_tx #(.WIDTH(16), .DET_PAT(4'b1011)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .len(len), .reps(reps),
    .abort(abort), .x(x), .valid(valid), .busy(busy), .done(done), .pat_cnt(pat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    bit xb;
    int pat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tot  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (valid || done) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_output: valid=%0d done=%0d x=%0d with nothing expected (cycle %0d)",
                 valid, done, x, cyc);
      end else begin
        e = sb.pop_front();
        chk("kind_done", int'(done), int'(e.is_done));
        chk("out_cycle", cyc, e.cyc);
        if (e.is_done) begin
          chk("done_pat_cnt", int'(pat_cnt), e.pat);
          chk("done_busy", int'(busy), 1);
          chk("done_valid", int'(valid), 0);
        end else begin
          chk("bit_x", int'(x), int'(e.xb));
        end
      end
    end
  end

  // Drives a start at the next negedge (cycle 0) and queues the MSB-first frame bits
  // (plus a parity bit per frame when enabled), truncated to nmax bits if nmax >= 0.
  task automatic launch(input logic [15:0] d, input int l, input int r,
                        input int nmax, input bit with_done, input int pat);
    bit   bits[$];
    bit   p;
    int   n;
    int   t0;
    exp_t en;
    for (int f = 0; f <= r; f++) begin
      p = 1'b0;
      for (int i = l - 1; i >= 0; i--) begin
        bits.push_back(d[i]);
        p ^= d[i];
      end
`ifdef SEQ_GEN_TX_PARITY_EN
      bits.push_back(p);
`endif
    end
    @(negedge clk);
    data  = d;
    len   = 5'(l);
    reps  = 4'(r);
    start = 1'b1;
    t0    = cyc;
    n = 0;
    for (int j = 0; j < bits.size(); j++) begin
      if (nmax < 0 || j < nmax) begin
        en.is_done = 1'b0; en.xb = bits[j]; en.pat = 0; en.cyc = t0 + j + 1;
        sb.push_back(en);
        n++;
      end
    end
    if (with_done) begin
      en.is_done = 1'b1; en.xb = 1'b0; en.pat = pat; en.cyc = t0 + n + 1;
      sb.push_back(en);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL drain_timeout: %0d expected outputs never appeared, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; data = '0; len = '0; reps = '0;
    repeat (3) @(negedge clk);
    chk("rst_x", int'(x), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pat_cnt", int'(pat_cnt), 0);
    rst_n = 1'b1;

    // abort while idle does nothing
    abort = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_abort_busy", int'(busy), 0);
    abort = 1'b0;

    // single frame 1011 -> one match
    launch(16'b1011, 4, 0, -1, 1'b1, 1);
    chk("t1_busy", int'(busy), 1);
    drain();

    // overlapping matches in 1011011
    launch(16'b1011011, 7, 0, -1, 1'b1, 2);
    drain();

    // three back-to-back frames, history spans the frame boundaries
    launch(16'b1011, 4, 2, -1, 1'b1, 3);
    drain();
    repeat (5) @(negedge clk);
    chk("pat_hold_after_done", int'(pat_cnt), 3);

    // abort in cycle 3 of an 8-bit frame; extra start in cycle 2 is ignored
    launch(16'b10110110, 8, 0, 3, 1'b1, 0);
    @(negedge clk);
    data = 16'hffff; len = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_idle_after_done", int'(busy), 0);
    abort = 1'b0;
    drain();

    // synchronous reset in the middle of a frame, after one match has been counted
    launch(16'b1011011, 7, 0, 5, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("pre_reset_pat_cnt", int'(pat_cnt), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_x", int'(x), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_pat_cnt", int'(pat_cnt), 0);
    rst_n = 1'b1;
    drain();

    // illegal lengths are rejected
    data = 16'hffff; len = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0_busy", int'(busy), 0);
    len = 5'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len17_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("illegal_len_pat_cnt", int'(pat_cnt), 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
